fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller between the PC, the instruction cache and the decoder. It owns the fetch PC, issues one instruction-cache request at a time and absorbs the returned word into a small circular instruction queue that feeds the decoder under a valid/accept handshake. On a ROB redirect it flushes the queue, drops any in-flight return and restarts fetch from the redirect target.

## Interface
Parameters:
- QUEUE_DEPTH, 4: instruction-queue entries; power of two, ≥2.
- RESET_PC, 32'h0: fetch PC after reset.

Ports (widths from `ADDR_WIDTH` / `INS_WIDTH`, both 32):
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- rdy_in  input  1  global ready; low freezes all state and forces fetch2iCache_enable to 0.
- fetch2iCache_enable  output  1  single-cycle request pulse.
- fetch2iCache_address  output  ADDR  request PC; valid only with the enable.
- iCache2fetch_enable  input  1  single-cycle return pulse, ≥1 cycle after the request.
- iCache2fetch_return  input  INS  returned instruction.
- iCache2fetch_pc  input  ADDR  PC of the returned instruction.
- fetch2decoder_enable  output  1  queue head valid.
- fetch2decoder_ins  output  INS  head instruction.
- fetch2decoder_pc  output  ADDR  head PC.
- decoder2fetch_enable  input  1  decoder accepts the head this cycle.
- rob2fetch_jump_enable  input  1  redirect/flush request.
- rob2fetch_jump_pc  input  ADDR  redirect target.

## Operation
- State register `fetch_state`:
  - IDLE: no request outstanding.
  - BUSY: one request outstanding.
  - DISCARD: an outstanding return is stale and must be dropped.
- Issue condition: IDLE and count < QUEUE_DEPTH and no redirect this cycle.
  - On issue, pulse fetch2iCache_enable with address = pc and go to BUSY.
  - pc advances by 4 on the issue edge, wrapping mod 2^32.
- Return while BUSY: enqueue {return, iCache2fetch_pc} at the tail and go to IDLE.
- Return while DISCARD: drop the word and go to IDLE.
- Return while IDLE: a protocol error. The word is ignored and the state is unchanged.
- Dequeue when fetch2decoder_enable && decoder2fetch_enable: the head pointer advances.
- Enqueue and dequeue in the same cycle: count is unchanged.
- Redirect has the highest priority:
  - The queue is flushed: head = tail = count = 0.
  - pc <= rob2fetch_jump_pc.
  - Any enqueue or dequeue in the same cycle is discarded.
  - State transitions: BUSY → DISCARD; DISCARD stays DISCARD; IDLE stays IDLE.
  - A return arriving in the redirect cycle is dropped and the next state is IDLE, because that return was the only outstanding one.
- Count is registered. Issue is blocked when count == QUEUE_DEPTH, even if a dequeue happens in the same cycle (conservative by design). Because only one request is outstanding, the queue can never overflow.
- rdy_in low: all registers hold, no request is issued, and the decoder outputs stay driven from the held state. The icache is frozen by the same rdy_in.

## Timing
- Reset (rst_in high at an edge):
  - pc = RESET_PC; fetch_state = IDLE; count = head = tail = 0.
  - fetch2iCache_enable = 0, fetch2decoder_enable = 0.
  - fetch2decoder_ins, fetch2decoder_pc and fetch2iCache_address = 0.
  - Reset in mid-operation abandons any outstanding request; a return arriving in the first IDLE cycle after reset is ignored.
- First request: driven in the first cycle with rst_in low.
- Outputs:
  - fetch2iCache_enable/address: combinational from state, count and pc.
  - Decoder outputs: combinational from the queue head, which is a registered entry.
- Latency: a return at edge N is visible to the decoder in cycle N+1. The next request can issue in cycle N+1.
- Throughput: one instruction per (icache latency + 1) cycles.
- Redirect at edge R: the first request to the target is issued in cycle R+1 if the state is IDLE. If a request was in flight, issue waits until after the stale return has been dropped.

## Structure
- `ADDR_WIDTH`, `INS_WIDTH` and the fetch_state encodings (IDLE = 2'd0, BUSY = 2'd1, DISCARD = 2'd2) live in the shared def.v header.
- One sub-module, `fetch_queue`:
  - Circular FIFO of {ins, pc} with head/tail pointers of width log2(QUEUE_DEPTH) that wrap naturally.
  - Count has width log2(QUEUE_DEPTH)+1.
  - Synchronous flush input.
- fetch_ctrl itself holds the FSM, pc and the issue logic.

## Test plan
- Reset then idle decoder, icache latency 1, RESET_PC = 0:
  - Requests are issued to 0x0, 0x4, 0x8, 0xC.
  - After 4 returns, count = 4 and no further request is issued.
  - With decoder2fetch_enable = 1 for one cycle, the head PC 0x0 leaves the queue and a request to 0x10 is issued the next cycle.
- Streaming, decoder always accepting, latency 2:
  - Decoder sees PCs 0x0, 0x4, 0x8 in order, each valid for exactly one cycle.
  - One instruction every 3 cycles; no duplicates or gaps.
- Redirect while BUSY with target 0x100, stale return for 0x8 one cycle later:
  - The stale word never reaches the decoder.
  - The next request address is 0x100; the queue is empty immediately after the redirect edge.
- Redirect coincident with a return and a decoder accept:
  - Queue empty, state IDLE.
  - A request to the target is issued the next cycle, and the dequeue is not counted.
- rdy_in held low for 5 cycles mid-stream: no request pulse, and pc, count and head unchanged; operation resumes identically when rdy_in rises.
- rst_in asserted while BUSY with queue count 2:
  - The next cycle shows all outputs 0 and pc = RESET_PC.
  - A return one cycle after reset is ignored, and the first post-reset request goes to RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared widths, fetch FSM encoding and queue entry type
//
// Contents:
//   ADDR_WIDTH, INS_WIDTH  address and instruction widths (32)
//   fetch_state_t          IDLE = 0, BUSY = 1, DISCARD = 2
//   fetch_entry_t          {ins, pc} pair held in the instruction queue
//   next_pc()              sequential fetch successor, wraps mod 2^ADDR_WIDTH
package fetch_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INS_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INS_WIDTH-1:0]  ins;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

  function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] pc);
    return pc + ADDR_WIDTH'(4);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - icache, decoder and rob signals of the fetch controller
//
// Signals:
//   fetch2iCache_enable/address       request pulse and PC towards the icache
//   iCache2fetch_enable/return/pc     return pulse, instruction word and its PC
//   fetch2decoder_enable/ins/pc       queue head offered to the decoder
//   decoder2fetch_enable              decoder accepts the head
//   rob2fetch_jump_enable/jump_pc     redirect request and target
// Modports: master = fetch controller side, slave = environment side.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic                  fetch2iCache_enable;
  logic [ADDR_WIDTH-1:0] fetch2iCache_address;
  logic                  iCache2fetch_enable;
  logic [INS_WIDTH-1:0]  iCache2fetch_return;
  logic [ADDR_WIDTH-1:0] iCache2fetch_pc;
  logic                  fetch2decoder_enable;
  logic [INS_WIDTH-1:0]  fetch2decoder_ins;
  logic [ADDR_WIDTH-1:0] fetch2decoder_pc;
  logic                  decoder2fetch_enable;
  logic                  rob2fetch_jump_enable;
  logic [ADDR_WIDTH-1:0] rob2fetch_jump_pc;

  modport master (
    output fetch2iCache_enable, fetch2iCache_address,
    input  iCache2fetch_enable, iCache2fetch_return, iCache2fetch_pc,
    output fetch2decoder_enable, fetch2decoder_ins, fetch2decoder_pc,
    input  decoder2fetch_enable,
    input  rob2fetch_jump_enable, rob2fetch_jump_pc
  );

  modport slave (
    input  fetch2iCache_enable, fetch2iCache_address,
    output iCache2fetch_enable, iCache2fetch_return, iCache2fetch_pc,
    input  fetch2decoder_enable, fetch2decoder_ins, fetch2decoder_pc,
    output decoder2fetch_enable,
    output rob2fetch_jump_enable, rob2fetch_jump_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular {ins, pc} instruction queue with synchronous flush
//
// Ports:
//   clk_in, rst_in  clock, synchronous active-high reset
//   active          state advances only when high (global ready)
//   flush           empties the queue; overrides push and pop
//   push/push_entry write an entry at the tail
//   pop             retire the head (ignored when empty)
//   head_valid      queue not empty
//   head_entry      head entry, zero when empty
//   count           registered occupancy, 0..DEPTH
module fetch_queue
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         active,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  output logic                         head_valid,
  output fetch_entry_t                 head_entry,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_pop;
  logic             do_push;

  assign head_valid = (count != '0);
  // Zero when empty so the decoder outputs read 0 straight out of reset.
  assign head_entry = head_valid ? mem[head] : '0;
  assign do_pop     = pop && head_valid;
  assign do_push    = push;

  // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (active) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_push) tail <= tail + PTR_W'(1);
        if (do_pop)  head <= head + PTR_W'(1);
        if (do_push && !do_pop)      count <= count + CNT_W'(1);
        else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && active && !flush && do_push) mem[tail] <= push_entry;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch controller: fetch PC, icache issue, decoder queue
//
// Ports:
//   clk_in   clock
//   rst_in   synchronous active-high reset
//   rdy_in   global ready; low freezes all state and suppresses requests
//   bus      fetch_ctrl_if.master: icache request/return, decoder handshake,
//            rob redirect
// Parameters: QUEUE_DEPTH (power of two, >= 2), RESET_PC.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  fetch_ctrl_if.master  bus
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t          fetch_state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [CNT_W-1:0]      count;
  logic                  jump;
  logic                  ret;
  logic                  issue;
  logic                  flush;
  logic                  push;
  logic                  pop;
  logic                  head_valid;
  fetch_entry_t          head_entry;
  fetch_entry_t          ret_entry;

  assign jump = bus.rob2fetch_jump_enable;
  assign ret  = bus.iCache2fetch_enable;

  // Full check uses the registered count, so a same-cycle dequeue does not
  // unblock issue; with one request in flight the queue cannot overflow.
  assign issue = !rst_in && rdy_in && (fetch_state == IDLE)
              && (count < CNT_W'(QUEUE_DEPTH)) && !jump;

  // Redirect wins over everything: flush and discard same-cycle enq/deq.
  assign flush = rdy_in && jump;
  assign push  = rdy_in && !jump && ret && (fetch_state == BUSY);
  assign pop   = rdy_in && !jump && head_valid && bus.decoder2fetch_enable;

  assign ret_entry = '{ins: bus.iCache2fetch_return, pc: bus.iCache2fetch_pc};

  assign bus.fetch2iCache_enable  = issue;
  assign bus.fetch2iCache_address = issue ? pc : '0;
  assign bus.fetch2decoder_enable = head_valid;
  assign bus.fetch2decoder_ins    = head_entry.ins;
  assign bus.fetch2decoder_pc     = head_entry.pc;

  // A return seen in IDLE is a protocol error (or the leftover of a request
  // abandoned by reset) and is simply ignored.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc          <= RESET_PC;
      fetch_state <= IDLE;
    end else if (rdy_in) begin
      if (jump) begin
        pc <= bus.rob2fetch_jump_pc;
        // A return in the redirect cycle was the only outstanding one.
        if (ret)                       fetch_state <= IDLE;
        else if (fetch_state == BUSY)  fetch_state <= DISCARD;
      end else if (issue) begin
        pc          <= next_pc(pc);
        fetch_state <= BUSY;
      end else if (ret && (fetch_state != IDLE)) begin
        fetch_state <= IDLE;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .active     (rdy_in),
    .flush      (flush),
    .push       (push),
    .push_entry (ret_entry),
    .pop        (pop),
    .head_valid (head_valid),
    .head_entry (head_entry),
    .count      (count)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl with icache responder and queue model
module tb_fetch_ctrl;

  localparam int          QD  = 4;
  localparam logic [31:0] RPC = 32'h0;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .QUEUE_DEPTH (QD),
    .RESET_PC    (RPC)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus.master)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no request seen within bound", name);
  endtask

  // instruction word the icache returns for a given address
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5EED ^ (a * 3);
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc = RPC;
  bit          outst = 0;   // a request is in flight
  bit          stale = 0;   // the in-flight request was cancelled by a redirect
  bit          chk_on = 0;
  bit          exp_req = 0;

  // ---------------- icache responder ----------------
  int          lat = 1;
  int          pcnt[$];
  logic [31:0] paddr[$];
  bit          fire = 0;
  bit          dut_req = 0;
  logic [31:0] dut_addr = 0;

  task automatic compare_cycle();
    bit          e_val;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
    dut_req  = (bus.fetch2iCache_enable === 1'b1);
    dut_addr = bus.fetch2iCache_address;
    if (!chk_on) return;
    exp_req = !rst_in && rdy_in && !outst && (mq.size() < QD) && !bus.rob2fetch_jump_enable;
    e_val = (mq.size() > 0);
    e_ins = e_val ? mq[0].ins : 32'h0;
    e_pc  = e_val ? mq[0].pc  : 32'h0;
    chk("req_enable",  {31'b0, bus.fetch2iCache_enable}, {31'b0, exp_req});
    chk("req_address", bus.fetch2iCache_address, exp_req ? mpc : 32'h0);
    chk("dec_enable",  {31'b0, bus.fetch2decoder_enable}, {31'b0, e_val});
    chk("dec_ins",     bus.fetch2decoder_ins, e_ins);
    chk("dec_pc",      bus.fetch2decoder_pc, e_pc);
  endtask

  task automatic update_cycle();
    // icache is frozen by the same rdy_in
    if (rdy_in === 1'b1) begin
      if (fire) begin
        void'(pcnt.pop_front());
        void'(paddr.pop_front());
      end
      foreach (pcnt[i]) if (pcnt[i] > 1) pcnt[i] = pcnt[i] - 1;
      if (dut_req) begin
        pcnt.push_back(lat);
        paddr.push_back(dut_addr);
      end
    end
    if (rst_in === 1'b1) begin
      mq.delete();
      mpc   = RPC;
      outst = 0;
      stale = 0;
    end else if (rdy_in === 1'b1 && chk_on) begin
      if (bus.rob2fetch_jump_enable) begin
        mq.delete();
        mpc = bus.rob2fetch_jump_pc;
        if (fire) begin
          outst = 0;
          stale = 0;
        end else if (outst) begin
          stale = 1;
        end
      end else begin
        if (bus.decoder2fetch_enable && mq.size() > 0) void'(mq.pop_front());
        if (fire && outst) begin
          if (!stale) mq.push_back('{ins: bus.iCache2fetch_return, pc: bus.iCache2fetch_pc});
          outst = 0;
          stale = 0;
        end
        if (exp_req) begin
          outst = 1;
          mpc   = mpc + 32'd4;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    fire = (pcnt.size() > 0) && (pcnt[0] == 1);
    bus.iCache2fetch_enable = fire;
    bus.iCache2fetch_pc     = fire ? paddr[0] : 32'h0;
    bus.iCache2fetch_return = fire ? word_of(paddr[0]) : 32'h0;
    #2;
    compare_cycle();
  end

  always @(posedge clk) update_cycle();

  // ---------------- stimulus ----------------
  bit          s_rst  = 1;
  bit          s_rdy  = 1;
  bit          s_jump = 0;
  bit          s_acc  = 0;
  logic [31:0] s_jpc  = 0;

  task automatic step();
    @(negedge clk);
    rst_in                    = s_rst;
    rdy_in                    = s_rdy;
    bus.rob2fetch_jump_enable = s_jump;
    bus.rob2fetch_jump_pc     = s_jpc;
    bus.decoder2fetch_enable  = s_acc;
    #3;
  endtask

  task automatic wait_req(input string name, output logic [31:0] addr);
    for (int i = 0; i < 20; i++) begin
      step();
      if (dut_req) begin
        addr = dut_addr;
        return;
      end
    end
    timeout_fail(name);
    addr = 32'hDEAD_BEEF;
  endtask

  logic [31:0] got[$];
  logic [31:0] a;

  initial begin
    bus.rob2fetch_jump_enable = 1'b0;
    bus.rob2fetch_jump_pc     = 32'h0;
    bus.decoder2fetch_enable  = 1'b0;

    // ---- fill with idle decoder, latency 1 ----
    s_rst = 1; step(); step();
    chk_on = 1;
    s_rst = 0; lat = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (dut_req) got.push_back(dut_addr);
    end
    chk("fill_req_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("fill_req_addr", got[i], i * 4);
    chk("full_no_req", {31'b0, bus.fetch2iCache_enable}, 32'h0);
    chk("full_head_pc", bus.fetch2decoder_pc, 32'h0);
    chk("full_head_ins", bus.fetch2decoder_ins, 32'hC0DE_5EED);
    s_acc = 1; step();
    chk("accept_cycle_no_req", {31'b0, bus.fetch2iCache_enable}, 32'h0);
    s_acc = 0; step();
    chk("after_accept_req", {31'b0, bus.fetch2iCache_enable}, 32'h1);
    chk("after_accept_addr", bus.fetch2iCache_address, 32'h10);
    chk("after_accept_head", bus.fetch2decoder_pc, 32'h4);
    step(); step();

    // ---- redirect while BUSY, latency 2 ----
    lat = 2; s_rst = 1; step(); s_rst = 0;
    wait_req("redir_req0", a); chk("redir_req0_addr", a, 32'h0);
    wait_req("redir_req1", a); chk("redir_req1_addr", a, 32'h4);
    wait_req("redir_req2", a); chk("redir_req2_addr", a, 32'h8);
    s_jump = 1; s_jpc = 32'h100; step();
    chk("redir_cycle_no_req", {31'b0, bus.fetch2iCache_enable}, 32'h0);
    s_jump = 0; step();
    chk("redir_queue_empty", {31'b0, bus.fetch2decoder_enable}, 32'h0);
    chk("redir_discard_no_req", {31'b0, bus.fetch2iCache_enable}, 32'h0);
    step();
    chk("redir_target_req", {31'b0, bus.fetch2iCache_enable}, 32'h1);
    chk("redir_target_addr", bus.fetch2iCache_address, 32'h100);
    step(); step(); step();
    chk("redir_head_pc", bus.fetch2decoder_pc, 32'h100);
    chk("redir_head_ins", bus.fetch2decoder_ins, word_of(32'h100));

    // ---- redirect coincident with return and accept, latency 1 ----
    lat = 1;
    wait_req("coinc_req", a);
    s_jump = 1; s_jpc = 32'h200; s_acc = 1; step();
    chk("coinc_ret_present", {31'b0, bus.iCache2fetch_enable}, 32'h1);
    s_jump = 0; s_acc = 0; step();
    chk("coinc_queue_empty", {31'b0, bus.fetch2decoder_enable}, 32'h0);
    chk("coinc_req_target", {31'b0, bus.fetch2iCache_enable}, 32'h1);
    chk("coinc_addr_target", bus.fetch2iCache_address, 32'h200);
    step(); step();
    chk("coinc_head_pc", bus.fetch2decoder_pc, 32'h200);

    // ---- streaming with rdy_in low for 5 cycles ----
    lat = 2; s_acc = 1;
    for (int i = 0; i < 7; i++) step();
    s_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rdy_low_no_req", {31'b0, bus.fetch2iCache_enable}, 32'h0);
    end
    s_rdy = 1;
    for (int i = 0; i < 12; i++) step();

    // ---- reset while BUSY with two queued entries, latency 3 ----
    s_acc = 0;
    for (int i = 0; i < 40 && pcnt.size() > 0; i++) step();
    lat = 3; s_rst = 1; step(); s_rst = 0;
    wait_req("rst_req0", a);
    wait_req("rst_req1", a);
    wait_req("rst_req2", a); chk("rst_req2_addr", a, 32'h8);
    s_rst = 1; step();
    chk("rst_first_no_req", {31'b0, bus.fetch2iCache_enable}, 32'h0);
    step();
    chk("rst_out_req", {31'b0, bus.fetch2iCache_enable}, 32'h0);
    chk("rst_out_addr", bus.fetch2iCache_address, 32'h0);
    chk("rst_out_dec_en", {31'b0, bus.fetch2decoder_enable}, 32'h0);
    chk("rst_out_dec_ins", bus.fetch2decoder_ins, 32'h0);
    chk("rst_out_dec_pc", bus.fetch2decoder_pc, 32'h0);
    s_rst = 0; step();
    chk("rst_stale_ret_present", {31'b0, bus.iCache2fetch_enable}, 32'h1);
    chk("rst_first_req", {31'b0, bus.fetch2iCache_enable}, 32'h1);
    chk("rst_first_addr", bus.fetch2iCache_address, RPC);
    step();
    chk("rst_stale_dropped", {31'b0, bus.fetch2decoder_enable}, 32'h0);
    step(); step(); step();
    chk("rst_head_pc", bus.fetch2decoder_pc, RPC);

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 3000; n++) begin
      if (pcnt.size() == 0) lat = $urandom_range(1, 3);
      s_acc  = ($urandom_range(0, 9) < 7);
      s_rdy  = ($urandom_range(0, 9) != 0);
      s_jump = ($urandom_range(0, 29) == 0);
      s_jpc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      step();
    end
    s_rdy = 1; s_jump = 0; s_acc = 1;
    for (int i = 0; i < 10; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
